// File: rtl/imem_pkg.sv
// Shared types for the instruction-memory read responder.
//   state_e     : transaction FSM states
//   RESP_*      : AXI-style read response codes
package imem_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DELAY = 2'd1,
        RESP  = 2'd2
    } state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/imem_rd_responder_lfsr8.sv
// 8-bit Fibonacci LFSR (taps 8,6,5,4) used to pick pseudo-random response delays.
//   clk, rst : clock, async active-high reset (loads SEED)
//   en       : advance one step
//   q        : current LFSR value
module lfsr8 #(
    parameter logic [7:0] SEED = 8'h5a
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    output logic [7:0] q
);

    logic [7:0] q_q;
    logic [7:0] q_d;
    logic       fb_c;

    // Taps 8,6,5,4 in 1-based numbering map to bits 7,5,4,3.
    assign fb_c = q_q[7] ^ q_q[5] ^ q_q[4] ^ q_q[3];

    always_comb begin
        q_d = q_q;
        if (en) begin
            q_d = {q_q[6:0], fb_c};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q <= SEED;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/imem_rd_responder.sv
// Read responder for the instruction-fetch channel, served from a preloadable
// word memory with a fixed or LFSR-driven response delay.
//   clk, rst                  : clock, async active-high reset
//   araddr/arvalid/arready    : read address channel
//   rdata/rvalid/rresp/rready : read response channel
//   mem_we/mem_waddr/mem_wdata: side preload port (word indexed)
module imem_rd_responder
    import imem_pkg::*;
#(
    parameter logic [31:0] BASE        = 32'h8000_0000,
    parameter int unsigned DEPTH       = 1024,
    parameter bit          RANDOM      = 1'b0,
    parameter int unsigned FIXED_DELAY = 0,
    parameter logic [7:0]  DELAY_MASK  = 8'h1f,
    parameter logic [7:0]  SEED        = 8'h5a
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [31:0]              araddr,
    input  logic                     arvalid,
    output logic                     arready,
    output logic [31:0]              rdata,
    output logic                     rvalid,
    output logic [1:0]               rresp,
    input  logic                     rready,
    input  logic                     mem_we,
    input  logic [$clog2(DEPTH)-1:0] mem_waddr,
    input  logic [31:0]              mem_wdata
);

    localparam int unsigned AW   = $clog2(DEPTH);
    localparam logic [32:0] SPAN = 33'(4 * DEPTH);

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] rdata_q, rdata_d;
    logic [1:0]  rresp_q, rresp_d;
    logic        rvalid_q, rvalid_d;
    logic        arready_q, arready_d;

    logic        lfsr_en_c;
    logic [7:0]  lfsr_c;
    logic [31:0] offset_c;
    logic        in_range_c;
    logic [AW-1:0] word_idx_c;

    logic [31:0] mem [DEPTH];

    lfsr8 #(.SEED(SEED)) u_lfsr (
        .clk (clk),
        .rst (rst),
        .en  (lfsr_en_c),
        .q   (lfsr_c)
    );

    // Preload port; memory image survives reset. Nonblocking write gives
    // read-before-write when the capture edge hits the same word.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // Addresses below BASE wrap to a large offset and fall outside SPAN.
    assign offset_c   = addr_q - BASE;
    assign in_range_c = ({1'b0, offset_c} < SPAN);
    assign word_idx_c = offset_c[AW+1:2];

    // Next-state and response logic.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        rvalid_d  = rvalid_q;
        arready_d = arready_q;
        lfsr_en_c = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (arvalid && arready_q) begin
                    addr_d    = araddr;
                    cnt_d     = RANDOM ? (lfsr_c & DELAY_MASK) : 8'(FIXED_DELAY);
                    lfsr_en_c = 1'b1;
                    arready_d = 1'b0;
                    state_d   = DELAY;
                end
            end
            DELAY: begin
                if (cnt_q != 8'd0) begin
                    cnt_d = cnt_q - 8'd1;
                end else begin
                    if (!in_range_c) begin
                        rresp_d = RESP_DECERR;
                        rdata_d = 32'd0;
                    end else if (addr_q[1:0] != 2'b00) begin
                        rresp_d = RESP_SLVERR;
                        rdata_d = 32'd0;
                    end else begin
                        rresp_d = RESP_OKAY;
                        rdata_d = mem[word_idx_c];
                    end
                    rvalid_d = 1'b1;
                    state_d  = RESP;
                end
            end
            RESP: begin
                if (rready) begin
                    rvalid_d  = 1'b0;
                    arready_d = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= 8'd0;
            addr_q    <= 32'd0;
            rdata_q   <= 32'd0;
            rresp_q   <= RESP_OKAY;
            rvalid_q  <= 1'b0;
            arready_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            rvalid_q  <= rvalid_d;
            arready_q <= arready_d;
        end
    end

    assign arready = arready_q;
    assign rvalid  = rvalid_q;
    assign rdata   = rdata_q;
    assign rresp   = rresp_q;

endmodule

// File: tb/tb_imem_rd_responder.sv
// Randomized bench: three responders (delay 0, delay 5, LFSR delay) share the
// preload port and reset; responses are compared against a behavioural model.
module tb_imem_rd_responder;

    localparam logic [31:0] BASE  = 32'h8000_0000;
    localparam int unsigned DEPTH = 1024;
    localparam int          NI    = 3;

    logic        clk;
    logic        rst;
    logic [31:0] araddr  [NI];
    logic        arvalid [NI];
    logic        arready [NI];
    logic [31:0] rdata   [NI];
    logic        rvalid  [NI];
    logic [1:0]  rresp   [NI];
    logic        rready  [NI];
    logic        mem_we;
    logic [9:0]  mem_waddr;
    logic [31:0] mem_wdata;

    int fixed_d [NI] = '{0, 5, 0};
    bit is_rand [NI] = '{1'b0, 1'b0, 1'b1};

    logic [31:0] ref_mem [DEPTH];
    logic [7:0]  ref_lfsr;
    int n_checks = 0;
    int n_err    = 0;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        imem_rd_responder #(
            .BASE        (BASE),
            .DEPTH       (DEPTH),
            .RANDOM      (g == 2),
            .FIXED_DELAY ((g == 1) ? 5 : 0),
            .DELAY_MASK  (8'h1f),
            .SEED        (8'h5a)
        ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .araddr    (araddr[g]),
            .arvalid   (arvalid[g]),
            .arready   (arready[g]),
            .rdata     (rdata[g]),
            .rvalid    (rvalid[g]),
            .rresp     (rresp[g]),
            .rready    (rready[g]),
            .mem_we    (mem_we),
            .mem_waddr (mem_waddr),
            .mem_wdata (mem_wdata)
        );
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Fibonacci step with taps 8,6,5,4 (1-based) written from the polynomial.
    function automatic logic [7:0] lfsr_next(input logic [7:0] v);
        int taps [4] = '{8, 6, 5, 4};
        logic fb = 1'b0;
        foreach (taps[i]) fb ^= v[taps[i] - 1];
        return {v[6:0], fb};
    endfunction

    function automatic void ref_resp(input logic [31:0] a, output logic [1:0] rr, output logic [31:0] rd);
        longint unsigned al = longint'(a);
        longint unsigned bl = longint'(BASE);
        if (al < bl || al >= bl + 4 * DEPTH) begin
            rr = 2'b11; rd = 32'd0;
        end else if (a % 4 != 0) begin
            rr = 2'b10; rd = 32'd0;
        end else begin
            rr = 2'b00; rd = ref_mem[int'((al - bl) / 4)];
        end
    endfunction

    function automatic logic [31:0] rand_addr();
        int sel = $urandom_range(0, 9);
        int idx = ($urandom_range(0, 7) == 0) ? 1023 : $urandom_range(0, 63);
        case (sel)
            0:       return BASE - 32'(4 * $urandom_range(1, 100));
            1:       return BASE + 32'h1000 + 32'(4 * $urandom_range(0, 100));
            2:       return BASE + 32'(4 * idx) + 32'($urandom_range(1, 3));
            default: return BASE + 32'(4 * idx);
        endcase
    endfunction

    task automatic preload(input int idx, input logic [31:0] d);
        mem_we = 1'b1; mem_waddr = 10'(idx); mem_wdata = d;
        @(posedge clk); #1;
        mem_we = 1'b0;
        ref_mem[idx] = d;
    endtask

    // One full read on instance k; hold = cycles rready stays low after rvalid.
    task automatic do_read(input int k, input logic [31:0] a, input int hold);
        int d;
        int n;
        logic [1:0]  er;
        logic [31:0] ed;
        d = is_rand[k] ? int'(ref_lfsr & 8'h1f) : fixed_d[k];
        if (is_rand[k]) ref_lfsr = lfsr_next(ref_lfsr);
        ref_resp(a, er, ed);
        check("arready_idle", 32'(arready[k]), 32'd1);
        araddr[k] = a; arvalid[k] = 1'b1; rready[k] = (hold == 0);
        @(posedge clk); #1;
        arvalid[k] = 1'b0; araddr[k] = $urandom;
        n = 0;
        while (!rvalid[k] && n < 300) begin
            check("arready_busy", 32'(arready[k]), 32'd0);
            @(posedge clk); #1;
            n++;
        end
        check("rvalid_latency", 32'(n), 32'(1 + d));
        check("rdata", rdata[k], ed);
        check("rresp", 32'(rresp[k]), 32'(er));
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            check("hold_rvalid", 32'(rvalid[k]), 32'd1);
            check("hold_rdata", rdata[k], ed);
            check("hold_rresp", 32'(rresp[k]), 32'(er));
            check("hold_arready", 32'(arready[k]), 32'd0);
        end
        rready[k] = 1'b1;
        @(posedge clk); #1;
        rready[k] = 1'b0;
        check("done_rvalid", 32'(rvalid[k]), 32'd0);
        check("done_arready", 32'(arready[k]), 32'd1);
    endtask

    initial begin
        logic [31:0] old_w;
        rst = 1'b1;
        mem_we = 1'b0; mem_waddr = '0; mem_wdata = '0;
        for (int k = 0; k < NI; k++) begin
            araddr[k] = '0; arvalid[k] = 1'b0; rready[k] = 1'b0;
        end
        ref_lfsr = 8'h5a;
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < NI; k++) begin
            check("rst_arready", 32'(arready[k]), 32'd1);
            check("rst_rvalid", 32'(rvalid[k]), 32'd0);
            check("rst_rdata", rdata[k], 32'd0);
            check("rst_rresp", 32'(rresp[k]), 32'd0);
        end

        preload(0, 32'h0000_0413);
        for (int i = 1; i < 64; i++) preload(i, $urandom);
        preload(1023, $urandom);
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed cases from the plan.
        do_read(0, 32'h8000_0000, 0);
        do_read(1, 32'h8000_0004, 0);
        do_read(1, 32'h8000_0008, 3);
        do_read(0, 32'h7FFF_FFFC, 0);
        do_read(0, 32'h8000_0002, 1);
        do_read(0, 32'h8000_1000, 0);
        do_read(0, 32'h8000_0FFC, 0);

        // Write to the word being captured on the same edge returns old data.
        old_w = ref_mem[2];
        araddr[0] = BASE + 32'd8; arvalid[0] = 1'b1; rready[0] = 1'b0;
        @(posedge clk); #1;
        arvalid[0] = 1'b0;
        mem_we = 1'b1; mem_waddr = 10'd2; mem_wdata = ~old_w;
        @(posedge clk); #1;
        mem_we = 1'b0;
        ref_mem[2] = ~old_w;
        check("rbw_rvalid", 32'(rvalid[0]), 32'd1);
        check("rbw_old_data", rdata[0], old_w);
        rready[0] = 1'b1;
        @(posedge clk); #1;
        rready[0] = 1'b0;
        do_read(0, BASE + 32'd8, 0);

        // Reset while the delay-5 responder is counting.
        araddr[1] = BASE + 32'd12; arvalid[1] = 1'b1;
        @(posedge clk); #1;
        arvalid[1] = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("midrst_rvalid", 32'(rvalid[1]), 32'd0);
        check("midrst_arready", 32'(arready[1]), 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        ref_lfsr = 8'h5a;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            check("post_rst_no_resp", 32'(rvalid[1]), 32'd0);
        end
        do_read(1, BASE + 32'd12, 0);

        // Randomized traffic; the LFSR instance does 50 back-to-back reads.
        for (int i = 0; i < 50; i++) do_read(2, rand_addr(), $urandom_range(0, 3));
        for (int i = 0; i < 10; i++) do_read(0, rand_addr(), $urandom_range(0, 3));
        for (int i = 0; i < 10; i++) do_read(1, rand_addr(), $urandom_range(0, 3));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
